arm_muldiv_unit: RTL
====================

Name: arm_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit, radix-2, one bit per cycle.
- Extends the single-cycle ARM datapath with SMULL, UMULL, UDIV and SDIV.
- Sits beside the ALU and is driven by the controller through a start/busy/done handshake.
- The controller stalls PC update while busy=1 and writes result_lo/result_hi into Rd/Rn when done=1.

Parameters:
WIDTH, 32, operand width in bits; must be >= 4.
CNTW, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only when busy=0
op  input  2  00 SMULL, 01 UMULL, 10 UDIV, 11 SDIV
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
result_lo  output  WIDTH  low product word / quotient
result_hi  output  WIDTH  high product word / remainder
flags  output  2  {N,Z} of the completed result
div_by_zero  output  1  last division had b==0

Behaviour:
- Clock and reset are named clk and reset. There is one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, div_by_zero = 0; result_lo, result_hi = 0; flags = 00.
- Reset has priority over everything else, including mid-operation.
- Reset during RUN or FIX aborts the operation. No done pulse is issued and all outputs return to their reset values.

States: IDLE, RUN, FIX, DONE.
- IDLE: busy=0, done=0. If start=1, capture op/a/b and load the counter with WIDTH, then go to RUN.
- RUN: busy=1. Perform one shift-add (mul) or one restoring shift-subtract (div) step and decrement the counter. When the counter reaches 1, go to FIX.
- FIX: busy=1. Apply sign correction, compute flags, register the outputs, then go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - If start=1 in DONE, accept the new operation immediately and go to RUN (back-to-back).
  - Otherwise go to IDLE.

Timing and start handling:
- Latency is fixed at WIDTH+2 cycles for every op and operand value, including divide by zero.
- If start is sampled in cycle 0, done is high in cycle WIDTH+2. For WIDTH=32 that is cycle 34.
- start while busy=1 is ignored. It has no effect on the in-flight operation and is not queued.
- op, a and b are don't-care except in the cycle where start is accepted.

Output holding:
- result_lo, result_hi, flags and div_by_zero update only on the FIX->DONE edge.
- They hold their values until the next FIX->DONE edge or reset.

Arithmetic:
- SMULL: signed a × signed b. The 2·WIDTH-bit two's-complement product is split as {result_hi, result_lo}.
  - Operands are converted to magnitudes at load. The product is negated in FIX when a[MSB]^b[MSB].
- UMULL: unsigned a × unsigned b, giving the full 2·WIDTH-bit product.
- UDIV: result_lo = a / b, result_hi = a mod b, both unsigned.
- SDIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Magnitudes are used internally, with sign fix-up in FIX.
  - a = most-negative and b = -1 gives quotient = most-negative (wraps) and remainder = 0, with no exception.
- Divide by zero (UDIV/SDIV with b==0): result_lo = 0, result_hi = a, div_by_zero = 1. Latency is unchanged.
- div_by_zero is cleared on completion of any operation whose b != 0, and on every multiply.

Flags:
- Multiply: N = result_hi[WIDTH-1]; Z = ({result_hi, result_lo} == 0).
- Divide: N = result_lo[WIDTH-1]; Z = (result_lo == 0).

Internal state:
- No combinational path from inputs to outputs.
- Internal accumulator is 2·WIDTH+1 bits. No overflow is possible.

Test Plan:
1. WIDTH=32, reset 2 cycles, then start with op=00, a=FFFFFFFD, b=00000007 -> done high exactly at cycle 34 for one cycle; result_lo=FFFFFFEB, result_hi=FFFFFFFF, flags=10; busy high in cycles 1..33.
2. op=01, a=FFFFFFFF, b=FFFFFFFF -> result_lo=00000001, result_hi=FFFFFFFE, flags=10. Then op=00, a=0, b=12345678 -> both words 0, flags=01.
3. op=10, a=100, b=7 -> result_lo=14, result_hi=2. Then op=11, a=-100, b=7 -> result_lo=FFFFFFF2, result_hi=FFFFFFFE, flags=10.
4. op=10, a=5, b=0 -> done at cycle 34, result_lo=0, result_hi=5, div_by_zero=1, flags=01. Next op=10, a=9, b=3 -> quotient 3, div_by_zero=0.
5. op=11, a=80000000, b=FFFFFFFF -> result_lo=80000000, result_hi=0, flags=10, div_by_zero=0.
6. Pulse start with different operands at cycles 5 and 20 of an op -> ignored; first results correct. Assert start during the DONE cycle -> new op's done exactly 34 cycles later. Assert reset at cycle 10 of an op -> next cycle busy=0, all outputs 0, no done pulse.

Source files
------------

// File: rtl/arm_muldiv_unit_if.sv
// Controller-side bundle for the iterative multiply/divide unit: request operands
// in, busy/done handshake and registered results out.
interface arm_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       flags;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags, div_by_zero
    );
endinterface

// File: rtl/arm_muldiv_unit.sv
// Radix-2 iterative SMULL/UMULL/UDIV/SDIV unit, one bit per cycle.
// Fixed WIDTH+2 cycle latency; new requests are taken only in IDLE or DONE.
module arm_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    arm_muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int AW = 2 * WIDTH + 1;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [1:0]        op_q;
    logic              sa_q, sb_q, bz_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [AW-1:0]     acc_q;
    logic [WIDTH-1:0]  lo_q, hi_q;
    logic [1:0]        flags_q;
    logic              dbz_q;
    logic              busy, done;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    logic             accept, in_signed, in_sa, in_sb;
    logic [WIDTH-1:0] in_ma, in_mb;

    assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
    assign in_signed = (bus.op == 2'b00) || (bus.op == 2'b11);
    assign in_sa     = in_signed & bus.a[WIDTH-1];
    assign in_sb     = in_signed & bus.b[WIDTH-1];
    assign in_ma     = mag(bus.a, in_sa);
    assign in_mb     = mag(bus.b, in_sb);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (cnt_q == CNTW'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN, FIX: busy = 1'b1;
            DONE:     done = 1'b1;
            default: ;
        endcase
    end

    // Multiply step: conditional add of the multiplicand into the upper half, then shift right.
    logic [WIDTH:0]  mul_sum;
    logic [AW-1:0]   mul_next;
    assign mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift in next dividend bit, keep the difference if it did not borrow.
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_trial;
    logic             div_ok;
    logic [AW-1:0]    div_next;
    assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = {1'b0, div_sh} - {2'b00, b_q};
    assign div_ok    = ~div_trial[WIDTH+1];
    assign div_next  = {(div_ok ? div_trial[WIDTH:0] : div_sh), acc_q[WIDTH-2:0], div_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            bz_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (accept) begin
            cnt_q <= CNTW'(WIDTH);
            op_q  <= bus.op;
            sa_q  <= in_sa;
            sb_q  <= in_sb;
            bz_q  <= (bus.b == '0);
            a_q   <= bus.a;
            b_q   <= bus.op[1] ? in_mb : in_ma;
            acc_q <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? in_ma : in_mb)};
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CNTW'(1);
            acc_q <= op_q[1] ? div_next : mul_next;
        end
    end

    // Sign fix-up and flag generation for the FIX cycle
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   fix_lo, fix_hi;
    logic [1:0]         fix_flags;
    logic               fix_dbz;

    assign prod_s = (sa_q ^ sb_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_s  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_lo    = '0;
        fix_hi    = '0;
        fix_flags = 2'b00;
        fix_dbz   = 1'b0;
        if (!op_q[1]) begin
            fix_lo    = prod_s[WIDTH-1:0];
            fix_hi    = prod_s[2*WIDTH-1:WIDTH];
            fix_flags = {prod_s[2*WIDTH-1], (prod_s == '0)};
        end else if (bz_q) begin
            fix_hi    = a_q;
            fix_flags = 2'b01;
            fix_dbz   = 1'b1;
        end else begin
            fix_lo    = quo_s;
            fix_hi    = rem_s;
            fix_flags = {quo_s[WIDTH-1], (quo_s == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= 2'b00;
            dbz_q   <= 1'b0;
        end else if (state_q == FIX) begin
            lo_q    <= fix_lo;
            hi_q    <= fix_hi;
            flags_q <= fix_flags;
            dbz_q   <= fix_dbz;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.result_lo   = lo_q;
    assign bus.result_hi   = hi_q;
    assign bus.flags       = flags_q;
    assign bus.div_by_zero = dbz_q;
endmodule
